io_port_bank: RTL
=================

IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the port data width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 2, the number of independent input and output channels (1..8).
REQ-003 The block SHALL have parameter IN_DEPTH, default 4, the input FIFO depth per channel (power of 2, at least 2).
REQ-004 Port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, width 1: reset, synchronous and active-high.
REQ-006 Port in_port, input, width CHANNELS*DATA_W: external input data, with channel k at bits [k*DATA_W +: DATA_W].
REQ-007 Port in_valid, input, width CHANNELS: per-channel external write request.
REQ-008 Port in_ready, output, width CHANNELS: per-channel space-available flag.
REQ-009 Port out_port, output, width CHANNELS*DATA_W: registered output data with the same packing as in_port.
REQ-010 Port out_strobe, output, width CHANNELS: one-cycle pulse marking an out_port channel update.
REQ-011 Port cpu_sel, input, width max(1,$clog2(CHANNELS)): channel selected for the CPU access.
REQ-012 Port cpu_rd, input, width 1: CPU pop request from the selected input FIFO.
REQ-013 Port cpu_wr, input, width 1: CPU write request to the selected output register.
REQ-014 Port cpu_wdata, input, width DATA_W: CPU write data.
REQ-015 Port cpu_rdata, output, width DATA_W: registered CPU read data.
REQ-016 Port cpu_rd_ok, output, width 1: pulse marking cpu_rdata as valid popped data.
REQ-017 Port in_overflow, output, width CHANNELS: sticky flag set when in_valid is high while in_ready is low.

Function
REQ-018 Each channel SHALL contain an IN_DEPTH-entry FIFO with a count from 0 to IN_DEPTH; read and write pointers SHALL wrap modulo IN_DEPTH.
REQ-019 in_ready[k] SHALL equal (count_k < IN_DEPTH) and not rst, decoded from registered count only.
REQ-020 A push on channel k SHALL occur when in_valid[k] and in_ready[k] are both high; the data SHALL be visible to a pop from the next cycle.
REQ-021 A push to a full FIFO SHALL be dropped and SHALL set in_overflow[k]; this holds even if a pop of the same channel occurs in that cycle.
REQ-022 cpu_rd with the selected FIFO non-empty SHALL pop the head entry; on the next cycle cpu_rdata SHALL equal that entry and cpu_rd_ok SHALL be 1 (latency 1).
REQ-023 cpu_rd with the selected FIFO empty SHALL pop nothing, SHALL hold cpu_rdata, and SHALL give cpu_rd_ok = 0 on the next cycle; there SHALL be no bypass of a push made in the same cycle.
REQ-024 A simultaneous push and pop on a non-empty, non-full channel SHALL leave its count unchanged and SHALL preserve FIFO order.
REQ-025 cpu_wr SHALL load cpu_wdata into out_port[cpu_sel] on the next edge, and out_strobe[cpu_sel] SHALL be 1 for exactly that following cycle.
REQ-026 out_strobe SHALL be 0 in every cycle not immediately following a cpu_wr.
REQ-027 cpu_rd and cpu_wr in the same cycle SHALL both execute independently.
REQ-028 A cpu_sel value of CHANNELS or higher SHALL make cpu_rd and cpu_wr no-ops, with cpu_rd_ok = 0.
REQ-029 in_overflow[k] SHALL remain set until reset; the CPU SHALL NOT clear it.
REQ-030 Channels SHALL be fully independent, except that they share the CPU access path.

Reset
REQ-031 While rst is high at an edge, the block SHALL empty all FIFOs (count 0, pointers 0).
REQ-032 While rst is high at an edge, out_port, out_strobe, cpu_rdata, cpu_rd_ok and in_overflow SHALL all be 0.
REQ-033 rst SHALL take priority over simultaneous push, pop or write; a reset asserted mid-operation SHALL discard buffered data.
REQ-034 in_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst falls.

Verification
REQ-035 Reset, then in_port ch0 = 0x0014 with in_valid[0] for 1 cycle, then cpu_sel=0 with cpu_rd -> cpu_rdata = 0x0014 and cpu_rd_ok = 1 one cycle later.
REQ-036 Push 0x0001..0x0004 into ch1 -> in_ready[1] = 0; push 0x0005 -> in_overflow[1] = 1; four pops -> 0x0001..0x0004 in order; fifth pop -> cpu_rd_ok = 0 and cpu_rdata stays 0x0004.
REQ-037 cpu_sel=1, cpu_wr, cpu_wdata = 0xBEEF -> out_port ch1 = 0xBEEF and a single-cycle out_strobe = 2'b10 next cycle; ch0 stays 0.
REQ-038 Fill ch0 to 4 entries, then push and pop in the same cycle -> pop returns the oldest entry, the push is dropped, and in_overflow[0] is set.
REQ-039 Hold 3 entries in ch0 and out_port ch0 = 0x1234, then assert rst for 1 cycle -> all outputs 0; the next pop gives cpu_rd_ok = 0.
REQ-040 Random push/pop/write traffic on CHANNELS=3, IN_DEPTH=8 against a scoreboard -> no ordering or data mismatch, and cpu_sel=3 accesses are ignored.

Source files
------------

// File: rtl/io_port_bank.sv
// io_port_bank: per-channel input FIFOs drained by a CPU read port, plus
// CPU-written output registers with a one-cycle update strobe per channel.
//
// Handshake: an external push on channel k happens on a rising edge where
// in_valid[k] and in_ready[k] are both high. in_ready[k] comes only from the
// registered occupancy and rst, so it never depends on in_valid or on CPU
// activity in the same cycle. A push offered while in_ready[k] is low is
// dropped and latches in_overflow[k] until the next reset.
module io_port_bank #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int IN_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [CHANNELS*DATA_W-1:0]                    in_port,
  input  logic [CHANNELS-1:0]                           in_valid,
  output logic [CHANNELS-1:0]                           in_ready,
  output logic [CHANNELS*DATA_W-1:0]                    out_port,
  output logic [CHANNELS-1:0]                           out_strobe,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cpu_sel,
  input  logic                                          cpu_rd,
  input  logic                                          cpu_wr,
  input  logic [DATA_W-1:0]                             cpu_wdata,
  output logic [DATA_W-1:0]                             cpu_rdata,
  output logic                                          cpu_rd_ok,
  output logic [CHANNELS-1:0]                           in_overflow
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = $clog2(IN_DEPTH);

  localparam logic [SEL_W:0] CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(IN_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // FIFO storage and bookkeeping, one set per channel
  logic [DATA_W-1:0] mem   [CHANNELS][IN_DEPTH];
  logic [PTR_W-1:0]  wptr  [CHANNELS];
  logic [PTR_W-1:0]  rptr  [CHANNELS];
  logic [PTR_W:0]    count [CHANNELS];

  logic                sel_ok;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [DATA_W-1:0]   head_data;

  // Out-of-range selects turn both CPU operations into no-ops
  assign sel_ok = ({1'b0, cpu_sel} < CH_LIM);

  // Decode ready, push/pop enables and the head entry of the selected FIFO
  always_comb begin
    sel_hit   = '0;
    push      = '0;
    pop       = '0;
    in_ready  = '0;
    head_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k]  = sel_ok && (cpu_sel == SEL_W'(k));
      in_ready[k] = (count[k] < DEPTH_C) && !rst;
      push[k]     = in_valid[k] && in_ready[k];
      // Pop only looks at the registered count: no bypass of a same-cycle push
      pop[k]      = cpu_rd && sel_hit[k] && (count[k] != '0);
      if (sel_hit[k]) begin
        head_data = mem[k][rptr[k]];
      end
    end
  end

  // FIFO data array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push[k]) begin
        mem[k][wptr[k]] <= in_port[k*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wptr[k]  <= '0;
        rptr[k]  <= '0;
        count[k] <= '0;
      end
      in_overflow <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push[k]) begin
          wptr[k] <= wptr[k] + PTR_ONE;
        end
        if (pop[k]) begin
          rptr[k] <= rptr[k] + PTR_ONE;
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CNT_ONE;
          2'b01:   count[k] <= count[k] - CNT_ONE;
          default: count[k] <= count[k];
        endcase
        // A full FIFO stays full for the whole cycle, even if popped now
        if (in_valid[k] && !in_ready[k]) begin
          in_overflow[k] <= 1'b1;
        end
      end
    end
  end

  // CPU read port: registered data, held when no pop happens
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= '0;
      cpu_rd_ok <= 1'b0;
    end else begin
      cpu_rd_ok <= |pop;
      if (|pop) begin
        cpu_rdata <= head_data;
      end
    end
  end

  // CPU write port: output registers and their one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      out_port   <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (cpu_wr && sel_hit[k]) begin
          out_port[k*DATA_W +: DATA_W] <= cpu_wdata;
          out_strobe[k]                <= 1'b1;
        end
      end
    end
  end

endmodule
